// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: FSM states, ALU op codes and the op legality check.
// Optional ALU_ARB_RR_EN selects a round-robin tie-break instead of fixed priority.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  function automatic logic is_legal_op(input logic [7:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      8'(OP_FWD),
      8'(OP_ADD),
      8'(OP_AND),
      8'(OP_OR): ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arb_if.sv
// Bus between the two requesters, the arbiter and the combinational ALU.
// slave = arbiter side, master = requesters plus ALU.
interface alu_arb_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data1;
  logic [WIDTH-1:0] req0_data2;
  logic [SEL_W-1:0] req0_select;
  logic             req0_grant;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data1;
  logic [WIDTH-1:0] req1_data2;
  logic [SEL_W-1:0] req1_select;
  logic             req1_grant;
  logic [WIDTH-1:0] alu_data1;
  logic [WIDTH-1:0] alu_data2;
  logic [SEL_W-1:0] alu_select;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_select,
    input  req1_valid, req1_data1, req1_data2, req1_select,
    input  alu_result, alu_zero,
    output req0_grant, req1_grant,
    output alu_data1, alu_data2, alu_select,
    output rsp_data, rsp_zero, rsp_err,
    output rsp0_valid, rsp1_valid, busy
  );

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_select,
    output req1_valid, req1_data1, req1_data2, req1_select,
    output alu_result, alu_zero,
    input  req0_grant, req1_grant,
    input  alu_data1, alu_data2, alu_select,
    input  rsp_data, rsp_zero, rsp_err,
    input  rsp0_valid, rsp1_valid, busy
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-way winner select; round-robin pointer when ALU_ARB_RR_EN is defined,
// otherwise requester 0 always wins a tie.
module alu_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic win1
);

`ifdef ALU_ARB_RR_EN
  logic ptr_q;

  // Pointer moves to whichever requester did not win.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~win1;
    end
  end

  always_comb begin
    win1 = valid1;
    if (valid0 && valid1) begin
      win1 = ptr_q;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, accept};
  assign win1 = valid1 & ~valid0;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, settle, capture, respond.
// Tie-break is round-robin when ALU_ARB_RR_EN is defined, fixed priority otherwise.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input logic      clk,
  input logic      reset,
  alu_arb_if.slave bus
);

  localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W = (S_EFF > 1) ? $clog2(S_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(S_EFF - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             capture;
  logic             win1;
  logic             owner_q;
  logic             legal;
  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] d2_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .accept (accept),
    .win1   (win1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!reset && (bus.req0_valid || bus.req1_valid)) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign legal = is_legal_op(8'(sel_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      sel_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= win1;
        d1_q    <= win1 ? bus.req1_data1  : bus.req0_data1;
        d2_q    <= win1 ? bus.req1_data2  : bus.req0_data2;
        sel_q   <= win1 ? bus.req1_select : bus.req0_select;
      end
      // Illegal ops still complete but report zeroed data with the error flag.
      if (capture) begin
        rsp_data_q <= legal ? bus.alu_result : '0;
        rsp_zero_q <= legal ? bus.alu_zero : 1'b0;
        rsp_err_q  <= ~legal;
      end
    end
  end

  assign bus.req0_grant = accept & ~win1;
  assign bus.req1_grant = accept & win1;
  assign bus.alu_data1  = d1_q;
  assign bus.alu_data2  = d2_q;
  assign bus.alu_select = sel_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp0_valid = (state_q == ST_RESP) & ~reset & ~owner_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) & ~reset & owner_q;
  assign bus.busy       = (state_q != ST_IDLE) & ~reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus reset, tie and abort sequences.
// Honours ALU_ARB_RR_EN for the expected tie-break order.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  typedef struct {
    int         r;
    logic [2:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] data;
    logic       zero;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[8];
  int   own[4];

  always #5 clk = ~clk;

  alu_arb_if #(.WIDTH(8), .SEL_W(3)) bus ();

  alu_arbiter #(
    .WIDTH(8), .SEL_W(3), .SETTLE_CYCLES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment ALU; illegal codes give junk the arbiter must mask.
  logic [7:0] alu_r;
  logic       alu_z;
  always_comb begin
    alu_r = 8'hAA;
    alu_z = 1'b1;
    case (bus.alu_select)
      OP_FWD:  alu_r = bus.alu_data1;
      OP_ADD:  alu_r = bus.alu_data1 + bus.alu_data2;
      OP_AND:  alu_r = bus.alu_data1 & bus.alu_data2;
      OP_OR:   alu_r = bus.alu_data1 | bus.alu_data2;
      default: alu_r = 8'hAA;
    endcase
    if (bus.alu_select < 3'd4) alu_z = (alu_r == 8'h00);
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = alu_z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] sel,
                         input logic [7:0] d1, input logic [7:0] d2);
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_select = sel;
      bus.req0_data1 = d1;   bus.req0_data2  = d2;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_select = sel;
      bus.req1_data1 = d1;   bus.req1_data2  = d2;
    end
  endtask

  // Called at an IDLE negedge with a request pending; returns at the next IDLE negedge.
  task automatic serve(input string tag, input int owner, input logic [7:0] data,
                       input logic zero, input logic err, input bit drop);
    #1;
    chk({tag, " grant0"}, 32'(bus.req0_grant), 32'(owner == 0));
    chk({tag, " grant1"}, 32'(bus.req1_grant), 32'(owner == 1));
    chk({tag, " idle busy"}, 32'(bus.busy), 0);
    @(posedge clk); #1;
    if (drop) begin
      if (owner == 0) bus.req0_valid = 1'b0;
      else            bus.req1_valid = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      chk({tag, " wait busy"}, 32'(bus.busy), 1);
      chk({tag, " wait rsp"}, 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
      chk({tag, " wait grant"}, 32'({bus.req0_grant, bus.req1_grant}), 0);
    end
    @(negedge clk);
    chk({tag, " rsp0_valid"}, 32'(bus.rsp0_valid), 32'(owner == 0));
    chk({tag, " rsp1_valid"}, 32'(bus.rsp1_valid), 32'(owner == 1));
    chk({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(data));
    chk({tag, " rsp_zero"}, 32'(bus.rsp_zero), 32'(zero));
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(err));
    @(negedge clk);
    chk({tag, " done busy"}, 32'(bus.busy), 0);
    chk({tag, " done rsp"}, 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, OP_ADD, 8'd5,   8'd3,   8'd8,   1'b0, 1'b0};
    vecs[1] = '{1, OP_FWD, 8'h3C,  8'h77,  8'h3C,  1'b0, 1'b0};
    vecs[2] = '{0, OP_AND, 8'hF0,  8'h0F,  8'h00,  1'b1, 1'b0};
    vecs[3] = '{1, OP_OR,  8'h12,  8'h40,  8'h52,  1'b0, 1'b0};
    vecs[4] = '{0, OP_ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0};
    vecs[5] = '{1, 3'b101, 8'h11,  8'h22,  8'h00,  1'b0, 1'b1};
    vecs[6] = '{0, 3'b111, 8'h55,  8'h66,  8'h00,  1'b0, 1'b1};
    vecs[7] = '{1, OP_ADD, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b0};
`ifdef ALU_ARB_RR_EN
    own = '{0, 1, 0, 1};
`else
    own = '{0, 0, 0, 0};
`endif

    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data1 = '0; bus.req0_data2 = '0; bus.req0_select = '0;
    bus.req1_valid = 1'b0; bus.req1_data1 = '0; bus.req1_data2 = '0; bus.req1_select = '0;
    set_req(0, OP_ADD, 8'd9, 8'd9);

    repeat (2) begin
      @(negedge clk);
      chk("reset grant0", 32'(bus.req0_grant), 0);
      chk("reset busy", 32'(bus.busy), 0);
      chk("reset alu_data1", 32'(bus.alu_data1), 0);
      chk("reset alu_select", 32'(bus.alu_select), 0);
      chk("reset rsp", 32'({bus.rsp_data, bus.rsp_zero, bus.rsp_err}), 0);
      chk("reset rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    end
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].r, vecs[i].sel, vecs[i].d1, vecs[i].d2);
      serve($sformatf("vec%0d", i), vecs[i].r, vecs[i].data,
            vecs[i].zero, vecs[i].err, 1'b1);
    end

    // Abort in WAIT: leaves pointer at 1 in RR build unless reset clears it.
    set_req(0, OP_ADD, 8'd1, 8'd1);
    #1;
    chk("abort grant0", 32'(bus.req0_grant), 1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort in-reset rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort alu_data1", 32'(bus.alu_data1), 0);
    chk("abort rsp_data", 32'(bus.rsp_data), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort no rsp", 32'({bus.rsp0_valid, bus.rsp1_valid}), 0);
      chk("abort idle", 32'(bus.busy), 0);
    end

    // Both requesters held valid across four operations.
    set_req(0, OP_OR,  8'hF0, 8'h0F);
    set_req(1, OP_AND, 8'hF0, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("tie%0d", k), own[k],
            (own[k] == 1) ? 8'h00 : 8'hFF, own[k] == 1, 1'b0, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    @(negedge clk);
    chk("hold alu_data1", 32'(bus.alu_data1), 32'hF0);
    chk("hold alu_data2", 32'(bus.alu_data2), 32'h0F);
    chk("hold alu_select", 32'(bus.alu_select), (own[3] == 1) ? 32'(OP_AND) : 32'(OP_OR));
    chk("hold rsp_data", 32'(bus.rsp_data), (own[3] == 1) ? 32'h00 : 32'hFF);
    chk("hold idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
